// File: rtl/spram_bus_ctrl.sv
// spram_bus_ctrl: load/store front-end for the 16K x 32 dual-SPRAM word memory.
// It turns byte-addressed RV32 requests into word address, lane-replicated
// write data, write enable and byte enables. It aligns and extends read data,
// flags illegal or misaligned accesses, and holds each response until the
// core takes it.
module spram_bus_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wen,
    output logic [3:0]        mem_ben,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;

    logic        accept;
    logic        code_ok;
    logic        misaligned;
    logic        legal;
    logic [3:0]  ben_calc;

    // Selects the addressed lane of a memory word and extends it by funct3.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b010:  load_extend = word;
            3'b100:  load_extend = {24'd0, b};
            3'b101:  load_extend = {16'd0, h};
            default: load_extend = 32'd0;
        endcase
    endfunction

    assign req_ready  = (state_q == ST_IDLE);
    assign accept     = req_valid & req_ready;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = req_addr[ADDR_W-1:2];
    assign legal      = code_ok & ~misaligned;
    assign mem_wen    = accept & req_we & legal;

    // Decodes access legality, alignment, lane enables and replicated store data.
    always_comb begin
        code_ok    = 1'b0;
        misaligned = 1'b0;
        ben_calc   = 4'b0000;
        mem_wdata  = req_wdata;
        case (req_funct3)
            3'b000: begin
                code_ok   = 1'b1;
                ben_calc  = 4'b0001 << req_addr[1:0];
                mem_wdata = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                code_ok    = 1'b1;
                misaligned = req_addr[0];
                ben_calc   = req_addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata  = {2{req_wdata[15:0]}};
            end
            3'b010: begin
                code_ok    = 1'b1;
                misaligned = (req_addr[1:0] != 2'b00);
                ben_calc   = 4'b1111;
                mem_wdata  = req_wdata;
            end
            3'b100: begin
                code_ok   = ~req_we;
                ben_calc  = 4'b0001 << req_addr[1:0];
                mem_wdata = {4{req_wdata[7:0]}};
            end
            3'b101: begin
                code_ok    = ~req_we;
                misaligned = req_addr[0];
                ben_calc   = req_addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata  = {2{req_wdata[15:0]}};
            end
            default: begin
                code_ok = 1'b0;
            end
        endcase
        if (mem_wen) begin
            mem_ben = ben_calc;
        end else begin
            mem_ben = 4'b0000;
        end
    end

    // Next-state and response-register logic for the IDLE/RD/RESP sequence.
    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        off_d        = off_q;
        f3_d         = f3_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!legal) begin
                        state_d      = ST_RESP;
                        resp_rdata_d = 32'd0;
                        resp_err_d   = 1'b1;
                    end else if (req_we) begin
                        state_d      = ST_RESP;
                        resp_rdata_d = 32'd0;
                        resp_err_d   = 1'b0;
                    end else begin
                        state_d = ST_RD;
                        off_d   = req_addr[1:0];
                        f3_d    = req_funct3;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                resp_rdata_d = load_extend(mem_rdata, off_q, f3_q);
                resp_err_d   = 1'b0;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and response registers; reset discards any in-flight response.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_IDLE;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            off_q        <= 2'd0;
            f3_q         <= 3'd0;
        end else begin
            state_q      <= state_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            off_q        <= off_d;
            f3_q         <= f3_d;
        end
    end

endmodule

// File: doc/spram_bus_ctrl.md
Name: spram_bus_ctrl

Overview:
Request/response front-end that sits directly upstream of the dual-SPRAM 32-bit word memory (16K x 32, 64 KiB). Converts core load/store requests (byte address, RV32 funct3 size/sign) into the memory's word address, replicated write data, write enable and byte enables. Aligns and sign/zero-extends read data, flags misaligned or illegal accesses, and holds the response until the core accepts it.

Parameters:
ADDR_W, 16, byte-address width; word address is ADDR_W-2 = 14 bits.

Ports:
clk  input  1  system clock
resetb  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted this cycle when high with req_valid
req_addr  input  ADDR_W  byte address
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32 size/sign code
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  response present
resp_ready  input  1  core accepts response
resp_rdata  output  32  load result, extended; 0 for stores and errors
resp_err  output  1  misaligned or illegal access
mem_addr  output  ADDR_W-2  word address to memory
mem_wdata  output  32  lane-replicated store data
mem_wen  output  1  memory write enable
mem_ben  output  4  byte enables, bit i = byte lane i
mem_rdata  input  32  memory read data, valid the cycle after the address edge

Behaviour:
- Clock is clk; reset is asynchronous and active-low on resetb. Reset: state IDLE, resp_valid 0, resp_err 0, resp_rdata 0, captured offset/funct3 0.
- FSM states: IDLE, RD, RESP. req_ready = (state == IDLE). Request accepted on an edge where req_valid and req_ready are both high.
- Memory outputs are combinational from the request:
  - mem_addr = req_addr[ADDR_W-1:2].
  - mem_wen = accept & req_we & legal.
  - mem_ben is 0 unless mem_wen is high.
- Legality:
  - funct3 000 and 001 are legal for load and store; 010 is legal for both.
  - 100 (LBU) and 101 (LHU) are legal for loads only; all other codes are illegal.
  - A half access with addr[0]=1 is misaligned. A word access with addr[1:0]!=0 is misaligned.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: addr[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
- mem_wdata:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Transitions:
  - IDLE, legal store accepted: write occurs on the accept edge; next state RESP with resp_rdata 0 and resp_err 0.
  - IDLE, legal load accepted: register addr[1:0] and funct3; next state RD.
  - RD: mem_rdata is valid. Select the lane by the stored offset, extend per funct3, and load it into resp_rdata. resp_err = 0; next state RESP.
  - IDLE, illegal or misaligned request accepted: no memory write. Next state RESP with resp_err 1 and resp_rdata 0.
  - RESP: resp_valid = 1, and resp_rdata/resp_err stay stable. On resp_ready the next state is IDLE and resp_valid drops.
- Latency:
  - Store: resp_valid is high in the cycle after acceptance.
  - Load: resp_valid is high 2 cycles after acceptance.
  - Minimum issue interval is 2 cycles for stores and 3 cycles for loads.
- Extension: LB/LH sign-extend bit 7/15 of the selected lane; LBU/LHU zero-extend.
- Reset mid-operation (RD or RESP) returns to IDLE and discards the response. A store already written on its accept edge remains in memory.
- resp_ready while not in RESP is ignored. req_valid while not in IDLE is held off by req_ready = 0.

Test Plan:
1. SW addr 0x0010, data 0xDEADBEEF: mem_addr=0x004, ben=1111, wen=1 for one cycle; resp_valid the next cycle, err=0. Then LW 0x0010: resp_rdata=0xDEADBEEF two cycles after acceptance.
2. SB addr 0x0013, data 0x000000A5: ben=1000, mem_wdata=0xA5A5A5A5. Then LB 0x0013 -> 0xFFFFFFA5; LBU 0x0013 -> 0x000000A5.
3. SH addr 0x0022, data 0x8001: ben=1100. LH 0x0022 -> 0xFFFF8001; LHU -> 0x00008001. SH addr 0x0021: wen stays 0, resp_err=1, and a following LW 0x0020 shows memory unchanged.
4. Illegal cases: store with funct3=100, and load with funct3=011. Both give wen=0, resp_err=1 and resp_rdata=0.
5. LW with resp_ready held low for 3 cycles: resp_valid and resp_rdata stay stable, req_ready stays 0, and a pending req_valid is not accepted. One cycle after resp_ready rises, req_ready=1.
6. resetb asserted low asynchronously while in RD: resp_valid=0, state IDLE and req_ready=1 immediately. After release, the next LW returns the correct data.
